// File: rtl/p1_debounce.sv
// P1 pushbutton conditioner: two-flop synchroniser followed by a counter-qualified
// four-state debounce FSM producing a clean level plus one-cycle rise/fall strobes.
//
// state     | meaning
// STABLE_LO | accepted level 0, waiting for a 1 on the synchronised input
// CHK_HI    | counting consecutive 1 samples before accepting the high level
// STABLE_HI | accepted level 1, waiting for a 0 on the synchronised input
// CHK_LO    | counting consecutive 0 samples before accepting the low level
module p1_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic P1,
    output logic p1_rise,
    output logic p1_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b10,
        CHK_LO    = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             p1_q, p1_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            p1_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p1_q    <= p1_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The sample that leaves a stable state counts as the first qualifying
    // sample, so acceptance happens on the DEBOUNCE_CYCLES-th consecutive one.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        p1_d    = p1_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s2_q) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    p1_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (s2_q) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    p1_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
            end
        endcase
    end

    assign P1      = p1_q;
    assign p1_rise = rise_q;
    assign p1_fall = fall_q;

endmodule

// File: tb/tb_p1_debounce.sv
// Bench for p1_debounce: a sliding-window reference model predicts P1 and the
// strobes per edge; predictions are queued at drive time and popped after the edge.
module tb_p1_debounce;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic P1;
    logic p1_rise;
    logic p1_fall;

    always #5 clk = ~clk;

    p1_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .P1      (P1),
        .p1_rise (p1_rise),
        .p1_fall (p1_fall)
    );

    typedef struct packed {
        logic p1;
        logic rise;
        logic fall;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rise, n_fall;
    int rise_cyc, fall_cyc;
    int mark;

    // model: sync pipeline, last N samples seen by the filter, accepted level
    logic         m_s1 = 1'b0;
    logic         m_s2 = 1'b0;
    logic         m_p1 = 1'b0;
    logic [N-1:0] m_win = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic b, input logic r);
        exp_t e;
        btn_raw = b;
        reset   = r;
        e = '0;
        if (r) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_p1  = 1'b0;
            m_win = '0;
        end else begin
            m_win = {m_win[N-2:0], m_s2};
            if (!m_p1 && m_win == {N{1'b1}}) begin
                m_p1   = 1'b1;
                e.rise = 1'b1;
            end else if (m_p1 && m_win == '0) begin
                m_p1   = 1'b0;
                e.fall = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
        e.p1 = m_p1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        chk("p1", {31'd0, P1}, {31'd0, e.p1});
        chk("rise", {31'd0, p1_rise}, {31'd0, e.rise});
        chk("fall", {31'd0, p1_fall}, {31'd0, e.fall});
        if (p1_rise === 1'b1) begin
            n_rise++;
            rise_cyc = cyc;
        end
        if (p1_fall === 1'b1) begin
            n_fall++;
            fall_cyc = cyc;
        end
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    task automatic clr_counts();
        n_rise   = 0;
        n_fall   = 0;
        rise_cyc = -1;
        fall_cyc = -1;
    endtask

    initial begin
        logic [5:0] pat;
        reset   = 1'b1;
        btn_raw = 1'b0;
        clr_counts();

        // 1: reset held with button pressed, then release
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("t1_rst_p1", {31'd0, P1}, 32'd0);
        chk("t1_rst_strobes", n_rise + n_fall, 0);
        mark = cyc + 1;
        hold(1'b1, 10);
        chk("t1_rise_count", n_rise, 1);
        chk("t1_rise_latency", rise_cyc - mark, 5);
        hold(1'b0, 10);

        // 2: short 2-cycle press is rejected
        clr_counts();
        hold(1'b1, 2);
        hold(1'b0, 10);
        chk("t2_rise_count", n_rise, 0);
        chk("t2_fall_count", n_fall, 0);

        // 3: 12-cycle press
        clr_counts();
        mark = cyc + 1;
        hold(1'b1, 12);
        hold(1'b0, 12);
        chk("t3_rise_count", n_rise, 1);
        chk("t3_fall_count", n_fall, 1);
        chk("t3_rise_latency", rise_cyc - mark, 5);
        chk("t3_fall_latency", fall_cyc - (mark + 12), 5);
        chk("t3_high_width", fall_cyc - rise_cyc, 12);

        // 4: bounce 1,0,1,0 then stable 1
        clr_counts();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        mark = cyc + 1;
        hold(1'b1, 10);
        chk("t4_rise_count", n_rise, 1);
        chk("t4_rise_latency", rise_cyc - mark, 5);
        hold(1'b0, 10);

        // 5: reset while qualifying a press (CHK_HI, cnt=2)
        clr_counts();
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        chk("t5_rst_p1", {31'd0, P1}, 32'd0);
        mark = cyc + 1;
        hold(1'b1, 10);
        chk("t5_rise_count", n_rise, 1);
        chk("t5_rise_latency", rise_cyc - mark, 5);
        hold(1'b0, 10);

        // 6: level pattern 1,1,1,0,1,1 at 8 cycles per level
        clr_counts();
        pat = 6'b110111;
        for (int k = 0; k < 6; k++) hold(pat[k], 8);
        chk("t6_rise_count", n_rise, 2);
        chk("t6_fall_count", n_fall, 1);
        hold(1'b0, 10);
        chk("t6_final_fall_count", n_fall, 2);
        chk("t6_final_p1", {31'd0, P1}, 32'd0);

        // random glitchy traffic against the model
        for (int k = 0; k < 300; k++) step(1'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 40; k++) hold(1'($urandom_range(0, 1)), $urandom_range(1, 7));

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
